// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix-vector MAC controller slice.
package mvm_pkg;

    localparam int SIZE_M    = 9;
    localparam int LOGSIZE_M = 4;
    localparam int SIZE_X    = 3;
    localparam int LOGSIZE_X = 2;
    localparam int ROWS      = SIZE_M / SIZE_X;

    typedef enum logic [2:0] {
        LOAD_M,
        LOAD_X,
        ISSUE,
        DRAIN,
        OUT
    } state_t;

    // A modulo-1 counter still needs one bit of storage.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mvm_ctrl_if.sv
// Handshake and memory-control bundle between the controller, its source and the datapath.
interface mvm_ctrl_if #(
    parameter int LOGSIZE_M = mvm_pkg::LOGSIZE_M,
    parameter int LOGSIZE_X = mvm_pkg::LOGSIZE_X
);
    logic                 s_valid;
    logic                 s_ready;
    logic [LOGSIZE_M-1:0] addr_M;
    logic                 wr_en_M;
    logic [LOGSIZE_X-1:0] addr_X;
    logic                 wr_en_X;
    logic                 clr_acc;
    logic                 acc_en;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        input  s_valid, m_ready,
        output s_ready, addr_M, wr_en_M, addr_X, wr_en_X, clr_acc, acc_en, m_valid
    );

    modport slave (
        output s_valid, m_ready,
        input  s_ready, addr_M, wr_en_M, addr_X, wr_en_X, clr_acc, acc_en, m_valid
    );
endinterface

// File: rtl/mvm_modcnt.sv
// Modulo-N up counter with enable, synchronous clear and terminal-count flag.
module mvm_modcnt #(
    parameter int N = 3,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         tc
);
    localparam logic [W-1:0] LAST = W'(N - 1);

    assign tc = (count == LAST);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/mvm_ctrl.sv
// Sequencer for the matrix-vector MAC: loads M then X, issues one row of reads per result,
// and holds each row result until the consumer takes it.
module mvm_ctrl #(
    parameter int SIZE_M    = mvm_pkg::SIZE_M,
    parameter int LOGSIZE_M = mvm_pkg::LOGSIZE_M,
    parameter int SIZE_X    = mvm_pkg::SIZE_X,
    parameter int LOGSIZE_X = mvm_pkg::LOGSIZE_X
) (
    input logic        clk,
    input logic        reset,
    mvm_ctrl_if.master bus
);
    import mvm_pkg::*;

    localparam int NUM_ROWS = SIZE_M / SIZE_X;
    localparam int ROW_W    = cnt_width(NUM_ROWS);
    localparam logic [LOGSIZE_M-1:0] M_LAST      = LOGSIZE_M'(SIZE_M - 1);
    localparam logic [LOGSIZE_M-1:0] X_LAST_LOAD = LOGSIZE_M'(SIZE_X - 1);
    localparam logic [LOGSIZE_X-1:0] X_LAST      = LOGSIZE_X'(SIZE_X - 1);

    state_t state, state_next;

    logic [LOGSIZE_M-1:0] load_cnt;
    logic                 load_tc;
    logic [LOGSIZE_X-1:0] k;
    logic                 k_tc;
    logic [ROW_W-1:0]     row_cnt;
    logic                 row_tc;
    logic [LOGSIZE_M-1:0] maddr;
    logic [LOGSIZE_M-1:0] row_last_addr;

    logic                 load_accept;
    logic                 x_done;
    logic                 out_hs;

    logic                 s_ready;
    logic [LOGSIZE_M-1:0] addr_M;
    logic                 wr_en_M;
    logic [LOGSIZE_X-1:0] addr_X;
    logic                 wr_en_X;
    logic                 clr_acc;
    logic                 acc_en;
    logic                 m_valid;

    assign load_accept = (state == LOAD_M || state == LOAD_X) && bus.s_valid;
    assign x_done      = (state == LOAD_X) && bus.s_valid && (load_cnt == X_LAST_LOAD);
    assign out_hs      = (state == OUT) && bus.m_ready;

    // The load counter is shared by both load phases; it wraps on its own after M and is
    // cleared explicitly after the shorter X phase.
    mvm_modcnt #(.N(SIZE_M), .W(LOGSIZE_M)) u_load_cnt (
        .clk(clk), .reset(reset), .en(load_accept), .clr(x_done),
        .count(load_cnt), .tc(load_tc)
    );

    mvm_modcnt #(.N(SIZE_X), .W(LOGSIZE_X)) u_k_cnt (
        .clk(clk), .reset(reset), .en(state == ISSUE), .clr(state == LOAD_X),
        .count(k), .tc(k_tc)
    );

    mvm_modcnt #(.N(NUM_ROWS), .W(ROW_W)) u_row_cnt (
        .clk(clk), .reset(reset), .en(out_hs), .clr(state == LOAD_X),
        .count(row_cnt), .tc(row_tc)
    );

    // Last matrix address read for the current row, held through DRAIN and OUT.
    assign row_last_addr = LOGSIZE_M'(row_cnt) * LOGSIZE_M'(SIZE_X) + X_LAST_LOAD;

    always_ff @(posedge clk) begin
        if (reset) begin
            maddr <= '0;
        end else if (state == LOAD_X) begin
            maddr <= '0;
        end else if (state == ISSUE) begin
            maddr <= (maddr == M_LAST) ? '0 : maddr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LOAD_M;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are forced low while reset is held, whatever state the register holds.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        addr_M     = '0;
        wr_en_M    = 1'b0;
        addr_X     = '0;
        wr_en_X    = 1'b0;
        clr_acc    = 1'b0;
        acc_en     = 1'b0;
        m_valid    = 1'b0;
        case (state)
            LOAD_M: begin
                s_ready = 1'b1;
                wr_en_M = bus.s_valid;
                addr_M  = load_cnt;
                if (bus.s_valid && load_tc) state_next = LOAD_X;
            end
            LOAD_X: begin
                s_ready = 1'b1;
                wr_en_X = bus.s_valid;
                addr_X  = load_cnt[LOGSIZE_X-1:0];
                if (x_done) state_next = ISSUE;
            end
            ISSUE: begin
                addr_M  = maddr;
                addr_X  = k;
                clr_acc = (k == '0);
                acc_en  = (k != '0);
                if (k_tc) state_next = DRAIN;
            end
            DRAIN: begin
                addr_M     = row_last_addr;
                addr_X     = X_LAST;
                acc_en     = 1'b1;
                state_next = OUT;
            end
            OUT: begin
                addr_M  = row_last_addr;
                addr_X  = X_LAST;
                m_valid = 1'b1;
                if (bus.m_ready) state_next = row_tc ? LOAD_M : ISSUE;
            end
            default: state_next = LOAD_M;
        endcase
        if (reset) begin
            s_ready = 1'b0;
            addr_M  = '0;
            wr_en_M = 1'b0;
            addr_X  = '0;
            wr_en_X = 1'b0;
            clr_acc = 1'b0;
            acc_en  = 1'b0;
            m_valid = 1'b0;
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.addr_M  = addr_M;
    assign bus.wr_en_M = wr_en_M;
    assign bus.addr_X  = addr_X;
    assign bus.wr_en_X = wr_en_X;
    assign bus.clr_acc = clr_acc;
    assign bus.acc_en  = acc_en;
    assign bus.m_valid = m_valid;
endmodule

// File: tb/tb_mvm_ctrl.sv
// Bench for mvm_ctrl: drives loads and result handshakes, models the MAC datapath and
// compares row results and write traffic against values derived from the loaded data.
module tb_mvm_ctrl;
    import mvm_pkg::*;

    localparam int NWORDS       = SIZE_M + SIZE_X;
    localparam int STALL_CYCLES = 6;
    localparam int N_FIXED      = 3;
    localparam int N_RAND       = 6;
    localparam int N_VEC        = N_FIXED + N_RAND;

    typedef struct {
        logic [SIZE_M-1:0][7:0] m;
        logic [SIZE_X-1:0][7:0] x;
        int                     gap_mode;
        int                     stall_row;
        bit                     noise;
        logic [ROWS-1:0][31:0]  exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;

    mvm_ctrl_if bus ();

    mvm_ctrl dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_ev  = 0;
    int m_writes = 0;
    int x_writes = 0;
    int word_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: registered memory reads, accumulate one edge later.
    logic [7:0]  mem_m [16];
    logic [7:0]  mem_x [4];
    logic [7:0]  rd_m, rd_x;
    logic [31:0] dp_acc;

    always @(posedge clk) begin
        if (bus.wr_en_M) mem_m[bus.addr_M] <= data_in;
        if (bus.wr_en_X) mem_x[bus.addr_X] <= data_in;
        rd_m <= mem_m[bus.addr_M];
        rd_x <= mem_x[bus.addr_X];
        if (bus.clr_acc) dp_acc <= '0;
        else if (bus.acc_en) dp_acc <= dp_acc + rd_m * rd_x;
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_row(input logic [SIZE_M-1:0][7:0] m,
                                            input logic [SIZE_X-1:0][7:0] x, input int r);
        logic [31:0] s = 0;
        for (int j = 0; j < SIZE_X; j++) s += 32'(m[r*SIZE_X + j]) * 32'(x[j]);
        return s;
    endfunction

    // Word stream model: the n-th accepted word of a load goes to M[n], then X[n-SIZE_M].
    always @(negedge clk) begin
        #2;
        if (reset) begin
            check_output("reset_outputs", {bus.s_ready, bus.wr_en_M, bus.wr_en_X, bus.clr_acc,
                                           bus.acc_en, bus.m_valid, bus.addr_M, bus.addr_X}, 0);
            word_idx = 0;
        end else begin
            check_output("output_exclusive",
                         32'((bus.m_valid && (bus.wr_en_M || bus.wr_en_X || bus.acc_en || bus.clr_acc))
                             || (bus.wr_en_M && bus.wr_en_X)), 0);
            if (bus.s_valid && bus.s_ready) begin
                if (word_idx < SIZE_M) begin
                    check_output("wr_en_M", 32'(bus.wr_en_M), 1);
                    check_output("wr_en_X_in_M", 32'(bus.wr_en_X), 0);
                    check_output("addr_M", 32'(bus.addr_M), word_idx);
                    m_writes++;
                end else begin
                    check_output("wr_en_X", 32'(bus.wr_en_X), 1);
                    check_output("wr_en_M_in_X", 32'(bus.wr_en_M), 0);
                    check_output("addr_X", 32'(bus.addr_X), word_idx - SIZE_M);
                    x_writes++;
                end
                word_idx = (word_idx == NWORDS - 1) ? 0 : word_idx + 1;
            end else begin
                check_output("no_write", {bus.wr_en_M, bus.wr_en_X}, 0);
            end
        end
    end

    task automatic load_matrix(input logic [SIZE_M-1:0][7:0] m, input logic [SIZE_X-1:0][7:0] x,
                               input int gap_mode);
        logic [7:0] words [NWORDS];
        int idx    = 0;
        int budget = 400;
        bit toggle = 1'b1;
        bit first  = 1'b1;
        bit v;
        for (int i = 0; i < SIZE_M; i++) words[i] = m[i];
        for (int j = 0; j < SIZE_X; j++) words[SIZE_M + j] = x[j];
        m_writes = 0;
        x_writes = 0;
        while (idx < NWORDS && budget > 0) begin
            @(negedge clk);
            budget--;
            case (gap_mode)
                0:       v = 1'b1;
                1:       begin v = toggle; toggle = !toggle; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.s_valid = v;
            bus.m_ready = 1'($urandom_range(0, 1));
            data_in     = v ? words[idx] : 8'($urandom);
            #1;
            if (first) begin
                check_output("s_ready_load_start", 32'(bus.s_ready), 1);
                first = 1'b0;
            end
            if (v && bus.s_ready) begin
                idx++;
                if (idx == NWORDS) last_ev = cyc;
            end
        end
        if (idx < NWORDS) check_output("load_timeout", idx, NWORDS);
    endtask

    task automatic collect(input int n_rows, input logic [ROWS-1:0][31:0] exp,
                           input int stall_row, input bit noise);
        int r          = 0;
        int stall_left = STALL_CYCLES;
        int budget     = 40 * ROWS;
        bit first      = 1'b1;
        while (r < n_rows && budget > 0) begin
            @(negedge clk);
            budget--;
            bus.m_ready = !(r == stall_row && stall_left > 0);
            bus.s_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            data_in     = 8'($urandom);
            #1;
            check_output("s_ready_busy", 32'(bus.s_ready), 0);
            if (bus.m_valid) begin
                if (first) begin
                    check_output("row_latency", cyc - last_ev, SIZE_X + 2);
                    first = 1'b0;
                end
                check_output("row_result", dp_acc, exp[r]);
                check_output("acc_quiet_in_out", {bus.acc_en, bus.clr_acc}, 0);
                if (bus.m_ready) begin
                    last_ev = cyc;
                    r++;
                    first = 1'b1;
                end else begin
                    stall_left--;
                end
            end
        end
        if (r < n_rows) check_output("result_timeout", r, n_rows);
    endtask

    task automatic apply_stimulus(input vec_t v);
        load_matrix(v.m, v.x, v.gap_mode);
        collect(ROWS, v.exp, v.stall_row, v.noise);
        check_output("m_write_count", m_writes, SIZE_M);
        check_output("x_write_count", x_writes, SIZE_X);
    endtask

    vec_t tbl [N_VEC];
    vec_t twos;

    initial begin
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_output("reset_s_ready", 32'(bus.s_ready), 0);
        check_output("reset_m_valid", 32'(bus.m_valid), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("s_ready_after_reset", 32'(bus.s_ready), 1);

        for (int t = 0; t < N_FIXED; t++) begin
            for (int i = 0; i < SIZE_M; i++) tbl[t].m[i] = 8'(i + 1);
            for (int j = 0; j < SIZE_X; j++) tbl[t].x[j] = 8'(j + 1);
            tbl[t].exp[0]    = 32'd14;
            tbl[t].exp[1]    = 32'd32;
            tbl[t].exp[2]    = 32'd50;
            tbl[t].gap_mode  = (t == 1) ? 1 : 0;
            tbl[t].stall_row = (t == 2) ? 1 : -1;
            tbl[t].noise     = (t == 2);
        end
        for (int t = N_FIXED; t < N_VEC; t++) begin
            for (int i = 0; i < SIZE_M; i++) tbl[t].m[i] = 8'($urandom);
            for (int j = 0; j < SIZE_X; j++) tbl[t].x[j] = 8'($urandom);
            for (int r = 0; r < ROWS; r++) tbl[t].exp[r] = ref_row(tbl[t].m, tbl[t].x, r);
            tbl[t].gap_mode  = 2;
            tbl[t].stall_row = int'($urandom_range(0, ROWS)) - 1;
            tbl[t].noise     = 1'($urandom_range(0, 1));
        end

        for (int t = 0; t < N_VEC; t++) apply_stimulus(tbl[t]);

        // Reset while row 1 is being issued, then reload a different matrix from word 0.
        load_matrix(tbl[0].m, tbl[0].x, 0);
        collect(1, tbl[0].exp, -1, 0);
        @(negedge clk);
        bus.m_ready = 1'b1;
        bus.s_valid = 1'b0;
        #1;
        check_output("row1_issue_clr", 32'(bus.clr_acc), 1);
        @(negedge clk);
        #1;
        check_output("row1_issue_acc", 32'(bus.acc_en), 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check_output("mid_reset_s_ready", 32'(bus.s_ready), 0);
        check_output("mid_reset_acc_en", 32'(bus.acc_en), 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("s_ready_after_mid_reset", 32'(bus.s_ready), 1);

        for (int i = 0; i < SIZE_M; i++) twos.m[i] = 8'd2;
        for (int j = 0; j < SIZE_X; j++) twos.x[j] = 8'd1;
        for (int r = 0; r < ROWS; r++) twos.exp[r] = 32'd6;
        twos.gap_mode  = 0;
        twos.stall_row = -1;
        twos.noise     = 1'b0;
        apply_stimulus(twos);
        apply_stimulus(tbl[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got no finish, want finish within budget");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mvm_ctrl.md
Name: mvm_ctrl

Overview:
Control FSM for the matrix-vector MAC datapath.
- Accepts a streamed SIZE_M-word row-major matrix M, then a SIZE_X-word vector X, through a valid/ready handshake.
- Generates the memory write strobes and addresses, sequences the per-row multiply-accumulate, and presents each row result with an m_valid/m_ready output handshake.
- Sits directly upstream of the datapath. data_in bypasses this block straight to the datapath; the datapath's data_out is the result qualified by m_valid.

Parameters:
SIZE_M, 9, number of matrix words
LOGSIZE_M, 4, width of addr_M
SIZE_X, 3, vector length and matrix row length
LOGSIZE_X, 2, width of addr_X
ROWS, SIZE_M/SIZE_X, number of result words per matrix

Ports:
clk  input  1  clock
reset  input  1  reset, synchronous, active-high
s_valid  input  1  upstream word valid
s_ready  output  1  block can accept a word
addr_M  output  LOGSIZE_M  matrix memory address
wr_en_M  output  1  matrix memory write strobe
addr_X  output  LOGSIZE_X  vector memory address
wr_en_X  output  1  vector memory write strobe
clr_acc  output  1  clear datapath accumulator at next edge
acc_en  output  1  datapath accumulator updates at next edge
m_valid  output  1  datapath result is valid
m_ready  input  1  downstream accepts result

Behaviour:
- Clock and reset: clk; reset is synchronous, active-high.
- Reset:
  - state LOAD_M; all counters 0.
  - All outputs 0 while reset is high. s_ready goes to 1 in the first cycle after reset deasserts.
- States: LOAD_M, LOAD_X, ISSUE, DRAIN, OUT.
- LOAD_M:
  - s_ready=1.
  - wr_en_M = s_valid (combinational). addr_M = load counter.
  - Counter increments per accepted word. After word SIZE_M-1 is accepted: counter clears, go to LOAD_X.
- LOAD_X:
  - Same as LOAD_M, using wr_en_X/addr_X and SIZE_X words.
  - After the last word: go to ISSUE with row=0, k=0, maddr=0.
- Word acceptance:
  - No write occurs when s_valid=0; counters hold.
  - s_ready=0 in ISSUE, DRAIN and OUT; s_valid is ignored there.
- ISSUE, one cycle per k=0..SIZE_X-1:
  - addr_M = maddr, addr_X = k.
  - clr_acc=1 only at k=0. acc_en=1 for k>=1.
  - maddr and k increment each cycle. After k=SIZE_X-1, go to DRAIN.
- DRAIN (one cycle): acc_en=1 for the final product; addresses hold their last values.
- Datapath timing: read latency 1, accumulate on the following edge. Row result is therefore valid in the cycle after DRAIN, i.e. SIZE_X+1 cycles after the first ISSUE cycle.
- OUT:
  - m_valid=1; acc_en=0 and clr_acc=0, so the result stays stable.
  - Held indefinitely until m_ready=1.
  - On handshake: if row<ROWS-1, row++, k=0, go to ISSUE (maddr continues). If row=ROWS-1, go to LOAD_M, which accepts the next matrix in the following cycle.
- Output qualification: wr_en_M, wr_en_X, acc_en and clr_acc are mutually exclusive with m_valid. wr_en_M and wr_en_X are never both 1.
- Per-row latency: SIZE_X+2 cycles from ISSUE entry to handshake with m_ready held at 1. For the default parameters this is 5 cycles per row.
- Reset in any state: returns to LOAD_M at the next edge. Partially loaded data is abandoned and must be reloaded from word 0.
- Width rules: maddr is LOGSIZE_M bits and never exceeds SIZE_M-1. k is LOGSIZE_X bits and wraps at SIZE_X.

Decomposition:
- Shared package mvm_pkg:
  - state enum (LOAD_M, LOAD_X, ISSUE, DRAIN, OUT)
  - default SIZE_M, SIZE_X, LOGSIZE_* localparams
  - ROWS derivation
- One sub-module is natural: mvm_modcnt, a parameterised modulo-N counter with enable, clear and terminal-count output. It is instantiated for the load counter, k and row.
- Top holds the FSM and maddr.

Test Plan:
- Load M=1..9 and X=1,2,3 with s_valid held at 1, m_ready=1 → exactly 9 wr_en_M pulses at addr 0..8 and 3 wr_en_X pulses at addr 0..2. Datapath outputs 14, 32, 50 with m_valid, each 5 cycles apart.
- Same load with s_valid toggling 1,0,1,0 → writes only in valid cycles; addresses contiguous; same results 14/32/50.
- Hold m_ready=0 for 6 cycles on row 1 → m_valid stays 1, value 32 stable, acc_en=0. Row 2 starts the cycle after m_ready=1.
- Assert s_valid during ISSUE/OUT → s_ready=0, no wr_en; memories unchanged; results unchanged.
- Assert reset during row 1's ISSUE → next cycle state LOAD_M, all outputs 0 during reset, s_ready=1 after. A fresh load of M=all 2 and X=all 1 gives 6, 6, 6.
- Second matrix back-to-back after the row-2 handshake → s_ready=1 on the next cycle; new results are correct and clr_acc leaves no residue from the previous 50.
